// File: rtl/frt_intc.sv
// Free-running timer interrupt slice: priority/vector registers on IBUS,
// prioritised ICI/OCIA/OCIB/OVI request to the CPU merge stage with ack.
// Ports:
//   CLK, RST (async, high), CE_R/CE_F phase enables, RES_N sync reset
//   ICI/OCIA/OCIB/OVI_IRQ  level interrupt flags from the timer
//   IBUS_*                 register bus (IPRB, VCRC, VCRD)
//   INT_REQ/LVL/VEC        request toward CPU; INT_ACK vector-fetch ack
//   ACK_VEC/ACK_VALID      vector latched at ack, one-cycle valid pulse
module frt_intc #(
   parameter logic [31:0] IPRB_ADDR = 32'hFFFFFE60,
   parameter logic [31:0] VCRC_ADDR = 32'hFFFFFE66,
   parameter logic [31:0] VCRD_ADDR = 32'hFFFFFE68
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        CE_R,
   input  logic        CE_F,
   input  logic        RES_N,
   input  logic        ICI_IRQ,
   input  logic        OCIA_IRQ,
   input  logic        OCIB_IRQ,
   input  logic        OVI_IRQ,
   input  logic [31:0] IBUS_A,
   input  logic [31:0] IBUS_DI,
   output logic [31:0] IBUS_DO,
   input  logic [3:0]  IBUS_BA,
   input  logic        IBUS_WE,
   input  logic        IBUS_REQ,
   output logic        IBUS_BUSY,
   output logic        IBUS_ACT,
   output logic        INT_REQ,
   output logic [3:0]  INT_LVL,
   output logic [6:0]  INT_VEC,
   input  logic        INT_ACK,
   output logic [6:0]  ACK_VEC,
   output logic        ACK_VALID
);

   localparam logic [15:0] IPRB_MASK = 16'h0F00;
   localparam logic [15:0] VCRC_MASK = 16'h7F7F;
   localparam logic [15:0] VCRD_MASK = 16'h7F00;

   typedef enum logic [1:0] {IDLE, PEND, ACK} state_t;

   state_t      state_q, state_d;
   logic [15:0] iprb, vcrc, vcrd;
   logic        hit_iprb, hit_vcrc, hit_vcrd;
   logic [15:0] wdata, wmask, rword;
   logic        wr_en;
   logic [3:0]  frtip;
   logic        src_any;
   logic [6:0]  sel_vec;
   logic        req_d, ackv_d;
   logic [3:0]  lvl_d;
   logic [6:0]  vec_d, ackvec_d;
   logic        unused_a0;

   assign unused_a0 = IBUS_A[0];

   assign hit_iprb = IBUS_A[31:1] == IPRB_ADDR[31:1];
   assign hit_vcrc = IBUS_A[31:1] == VCRC_ADDR[31:1];
   assign hit_vcrd = IBUS_A[31:1] == VCRD_ADDR[31:1];
   assign IBUS_ACT  = hit_iprb | hit_vcrc | hit_vcrd;
   assign IBUS_BUSY = 1'b0;

   // Byte enables of both bus halves fold onto the addressed halfword;
   // data comes from the lane selected by A[1].
   assign wdata = IBUS_A[1] ? IBUS_DI[15:0] : IBUS_DI[31:16];
   assign wmask = {{8{IBUS_BA[3] | IBUS_BA[1]}},
                   {8{IBUS_BA[2] | IBUS_BA[0]}}};
   assign wr_en = IBUS_REQ & IBUS_WE;

   function automatic logic [15:0] merge(input logic [15:0] old,
                                         input logic [15:0] d,
                                         input logic [15:0] m,
                                         input logic [15:0] keep);
      return ((old & ~m) | (d & m)) & keep;
   endfunction

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         iprb <= '0;
         vcrc <= '0;
         vcrd <= '0;
      end else if (CE_R) begin
         if (!RES_N) begin
            iprb <= '0;
            vcrc <= '0;
            vcrd <= '0;
         end else if (wr_en) begin
            if (hit_iprb) iprb <= merge(iprb, wdata, wmask, IPRB_MASK);
            if (hit_vcrc) vcrc <= merge(vcrc, wdata, wmask, VCRC_MASK);
            if (hit_vcrd) vcrd <= merge(vcrd, wdata, wmask, VCRD_MASK);
         end
      end
   end

   always_comb begin
      rword = '0;
      unique case (1'b1)
         hit_iprb: rword = iprb;
         hit_vcrc: rword = vcrc;
         hit_vcrd: rword = vcrd;
         default:  rword = '0;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         IBUS_DO <= '0;
      end else if (CE_R && !RES_N) begin
         IBUS_DO <= '0;
      end else if (CE_F) begin
         IBUS_DO <= (IBUS_REQ && !IBUS_WE && IBUS_ACT) ? {2{rword}} : '0;
      end
   end

   // Fixed internal order: ICI > OCIA|OCIB > OVI; FRTIP=0 masks all.
   assign frtip   = iprb[11:8];
   assign src_any = (ICI_IRQ | OCIA_IRQ | OCIB_IRQ | OVI_IRQ) &&
                    (frtip != 4'd0);
   assign sel_vec = ICI_IRQ              ? vcrc[14:8] :
                    (OCIA_IRQ | OCIB_IRQ) ? vcrc[6:0]  : vcrd[14:8];

   always_comb begin
      state_d  = state_q;
      req_d    = INT_REQ;
      lvl_d    = INT_LVL;
      vec_d    = INT_VEC;
      ackvec_d = ACK_VEC;
      ackv_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (src_any) begin
               state_d = PEND;
               req_d   = 1'b1;
               lvl_d   = frtip;
               vec_d   = sel_vec;
            end
         end
         PEND: begin
            // Ack beats a dropping source: the vector is already out.
            if (INT_ACK) begin
               state_d  = ACK;
               req_d    = 1'b0;
               lvl_d    = 4'd0;
               ackvec_d = INT_VEC;
               ackv_d   = 1'b1;
            end else if (!src_any) begin
               state_d = IDLE;
               req_d   = 1'b0;
               lvl_d   = 4'd0;
            end else begin
               lvl_d = frtip;
               vec_d = sel_vec;
            end
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= IDLE;
         INT_REQ   <= 1'b0;
         INT_LVL   <= '0;
         INT_VEC   <= '0;
         ACK_VEC   <= '0;
         ACK_VALID <= 1'b0;
      end else if (CE_R) begin
         if (!RES_N) begin
            state_q   <= IDLE;
            INT_REQ   <= 1'b0;
            INT_LVL   <= '0;
            INT_VEC   <= '0;
            ACK_VEC   <= '0;
            ACK_VALID <= 1'b0;
         end else begin
            state_q   <= state_d;
            INT_REQ   <= req_d;
            INT_LVL   <= lvl_d;
            INT_VEC   <= vec_d;
            ACK_VEC   <= ackvec_d;
            ACK_VALID <= ackv_d;
         end
      end
   end

endmodule
